// File: rtl/sw_fsm_pkg.sv
// Shared constants for the switch-driven LED state machine:
// state indices, default code/legality tables, LED modes.
package sw_fsm_pkg;

    localparam int DEF_SW_W   = 3;
    localparam int DEF_NUM_ST = 5;

    localparam int ST_IDLE = 0;
    localparam int ST_1    = 1;
    localparam int ST_2    = 2;
    localparam int ST_3    = 3;
    localparam int ST_4    = 4;

    // State k's code lives at [k*SW_W +: SW_W]
    localparam logic [DEF_NUM_ST*DEF_SW_W-1:0] DEF_ST_CODE = {
        3'b111, 3'b100, 3'b010, 3'b001, 3'b000
    };

    function automatic logic [DEF_NUM_ST*DEF_NUM_ST-1:0] edge_bit(
        input int from,
        input int to
    );
        logic [DEF_NUM_ST*DEF_NUM_ST-1:0] m;
        m = '0;
        m[from*DEF_NUM_ST+to] = 1'b1;
        return m;
    endfunction

    localparam logic [DEF_NUM_ST*DEF_NUM_ST-1:0] DEF_LEGAL =
        edge_bit(ST_IDLE, ST_1) | edge_bit(ST_IDLE, ST_2) |
        edge_bit(ST_1, ST_2)    | edge_bit(ST_1, ST_3)    |
        edge_bit(ST_2, ST_3)    |
        edge_bit(ST_3, ST_4)    | edge_bit(ST_3, ST_IDLE) |
        edge_bit(ST_4, ST_3);

    localparam logic MODE_STEADY = 1'b0;
    localparam logic MODE_BLINK  = 1'b1;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_e;

endpackage

// File: rtl/sw_qualifier.sv
// Debounce-style qualifier: raises a one-cycle request once the
// switch value has been stable for HOLD_CYC consecutive edges.
module sw_qualifier #(
    parameter int SW_W     = 3,
    parameter int HOLD_CYC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw,
    output logic            req_valid,
    output logic [SW_W-1:0] req_code
);

    localparam int CW = $clog2(HOLD_CYC + 1);

    logic [SW_W-1:0] sw_q;
    logic [CW-1:0]   stable_cnt;
    logic            same;

    assign same = (sw == sw_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_q       <= '0;
            stable_cnt <= '0;
        end else begin
            sw_q <= sw;
            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CW'(HOLD_CYC)) begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    // Fires on the edge that takes the counter to HOLD_CYC; saturation
    // keeps it from firing again within the same stable episode.
    assign req_valid = same && (stable_cnt == CW'(HOLD_CYC - 1));
    assign req_code  = sw_q;

endmodule

// File: rtl/sw_led_fsm_param.sv
// Switch-selected LED state machine with legality table,
// illegal-request pulse, transition counter and blink mode.
module sw_led_fsm_param
    import sw_fsm_pkg::*;
#(
    parameter int SW_W      = DEF_SW_W,
    parameter int NUM_ST    = DEF_NUM_ST,
    parameter int HOLD_CYC  = 4,
    parameter int BLINK_DIV = 8,
    parameter logic [NUM_ST*SW_W-1:0]   ST_CODE = DEF_ST_CODE,
    parameter logic [NUM_ST*NUM_ST-1:0] LEGAL   = DEF_LEGAL
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SW_W-1:0]           sw,
    input  logic                      mode,
    output logic [SW_W-1:0]           led,
    output logic [$clog2(NUM_ST)-1:0] state_o,
    output logic [7:0]                trans_cnt,
    output logic                      illegal
);

    localparam int ST_W = $clog2(NUM_ST);
    localparam int BW   = $clog2(BLINK_DIV);

    logic            req_valid;
    logic [SW_W-1:0] req_code;

    logic [ST_W-1:0] state_q, state_n;
    logic [SW_W-1:0] led_q, led_n;
    logic [7:0]      tc_q, tc_n;
    logic            ill_q, ill_n;
    logic [BW-1:0]   bcnt_q, bcnt_n;
    phase_e          phase_q, phase_n;

    logic            hit;
    logic [ST_W-1:0] tgt;
    logic            allowed;
    logic            act;
    logic            take;
    logic            wrap;

    sw_qualifier #(
        .SW_W     (SW_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_qual (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .req_valid (req_valid),
        .req_code  (req_code)
    );

    function automatic logic [SW_W-1:0] code_of(
        input logic [ST_W-1:0] s
    );
        logic [SW_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_ST; k++) begin
            if (s == ST_W'(k)) c = ST_CODE[k*SW_W +: SW_W];
        end
        return c;
    endfunction

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        for (int k = NUM_ST - 1; k >= 0; k--) begin
            if (ST_CODE[k*SW_W +: SW_W] == req_code) begin
                hit = 1'b1;
                tgt = ST_W'(k);
            end
        end
    end

    always_comb begin
        allowed = 1'b0;
        for (int f = 0; f < NUM_ST; f++) begin
            for (int t = 0; t < NUM_ST; t++) begin
                if (state_q == ST_W'(f) && tgt == ST_W'(t))
                    allowed = LEGAL[f*NUM_ST + t];
            end
        end
    end

    assign act  = req_valid && hit && (tgt != state_q);
    assign wrap = (bcnt_q == BW'(BLINK_DIV - 1));

    always_comb begin
        state_n = state_q;
        tc_n    = tc_q;
        ill_n   = 1'b0;
        take    = 1'b0;
        bcnt_n  = bcnt_q;
        phase_n = phase_q;
        led_n   = '0;

        unique case (1'b1)
            !act: begin
            end
            act && allowed: begin
                state_n = tgt;
                take    = 1'b1;
                if (tc_q != 8'hFF) tc_n = tc_q + 8'd1;
            end
            act && !allowed: begin
                ill_n = 1'b1;
            end
        endcase

        unique case (1'b1)
            take: begin
                bcnt_n  = '0;
                phase_n = PH_ON;
            end
            !take && wrap: begin
                bcnt_n  = '0;
                phase_n = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end
            !take && !wrap: begin
                bcnt_n = bcnt_q + BW'(1);
            end
        endcase

        if (mode == MODE_BLINK && phase_n == PH_OFF)
            led_n = '0;
        else
            led_n = code_of(state_n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_W'(ST_IDLE);
            led_q   <= '0;
            tc_q    <= '0;
            ill_q   <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= PH_ON;
        end else begin
            state_q <= state_n;
            led_q   <= led_n;
            tc_q    <= tc_n;
            ill_q   <= ill_n;
            bcnt_q  <= bcnt_n;
            phase_q <= phase_n;
        end
    end

    assign led       = led_q;
    assign state_o   = state_q;
    assign trans_cnt = tc_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_sw_led_fsm_param.sv
// Bench for sw_led_fsm_param: two instances (HOLD_CYC 4 and 1)
// tracked against a behavioural model of the state/LED rules.
module tb_sw_led_fsm_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [2:0] sw;

    logic [2:0] led_a, led_b, st_a, st_b;
    logic [7:0] tc_a, tc_b;
    logic       ill_a, ill_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sw_led_fsm_param #(.HOLD_CYC(4)) dut_a (
        .clk(clk), .reset(reset), .sw(sw), .mode(mode),
        .led(led_a), .state_o(st_a), .trans_cnt(tc_a), .illegal(ill_a)
    );

    sw_led_fsm_param #(.HOLD_CYC(1)) dut_b (
        .clk(clk), .reset(reset), .sw(sw), .mode(mode),
        .led(led_b), .state_o(st_b), .trans_cnt(tc_b), .illegal(ill_b)
    );

    // Reference model
    int code_tab[5] = '{0, 1, 2, 4, 7};
    bit legal_tab[5][5];
    int m_prev[2], m_run[2], m_st[2], m_tc[2], m_since[2];
    bit m_ill[2], m_mode[2];

    function automatic int hold_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        int tgt;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_prev[i] = 0; m_run[i] = 0; m_st[i] = 0;
                m_tc[i] = 0; m_since[i] = 0; m_ill[i] = 0; m_mode[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ill[i] = 0;
                m_since[i]++;
                m_mode[i] = mode;
                if (int'(sw) != m_prev[i]) begin
                    m_prev[i] = int'(sw);
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == hold_of(i)) begin
                        tgt = -1;
                        for (int k = 4; k >= 0; k--)
                            if (code_tab[k] == m_prev[i]) tgt = k;
                        if (tgt >= 0 && tgt != m_st[i]) begin
                            if (legal_tab[m_st[i]][tgt]) begin
                                m_st[i] = tgt;
                                m_tc[i] = (m_tc[i] < 255) ? m_tc[i] + 1 : 255;
                                m_since[i] = 0;
                            end else begin
                                m_ill[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [14:0] exp_vec(int i);
        logic [2:0] l;
        if (m_mode[i] == 0 || ((m_since[i] / 8) % 2) == 0)
            l = 3'(code_tab[m_st[i]]);
        else
            l = 3'b000;
        return {3'(m_st[i]), l, 8'(m_tc[i]), m_ill[i]};
    endfunction

    function automatic logic [14:0] act_vec(int i);
        if (i == 0) return {st_a, led_a, tc_a, ill_a};
        return {st_b, led_b, tc_b, ill_b};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sw = 3'b000;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sw = 3'b000; mode = 1'b0;
        cyc(3);
        n_chk++;
        if ({st_a, led_a, tc_a, ill_a} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_a got=%h exp=0", {st_a, led_a, tc_a, ill_a});
        end
        n_chk++;
        if ({st_b, led_b, tc_b, ill_b} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_b got=%h exp=0", {st_b, led_b, tc_b, ill_b});
        end
        reset = 1'b1;
        sw = 3'b001;
        cyc(6);
        n_chk++;
        if (st_a !== 3'd1 || tc_a !== 8'd1) begin
            n_err++;
            $display("FAIL pre_reset st=%0d tc=%0d exp 1/1", st_a, tc_a);
        end
        sw = 3'b111;
        cyc(2);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if ({st_a, led_a, tc_a} !== 14'd0) begin
            n_err++;
            $display("FAIL async_reset st=%0d led=%b tc=%0d exp 0", st_a, led_a, tc_a);
        end
        @(negedge clk);
        sw = 3'b000;
        reset = 1'b1;
    endtask

    task automatic test_walk();
        logic [2:0] codes[5] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b100};
        int exp_st[5] = '{1, 2, 3, 4, 3};
        logic [2:0] pa, pb;
        int la, lb;
        mode = 1'b0;
        for (int j = 0; j < 5; j++) begin
            pa = st_a; pb = st_b; la = -1; lb = -1;
            sw = codes[j];
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (la < 0 && st_a != pa) la = c;
                if (lb < 0 && st_b != pb) lb = c;
                for (int i = 0; i < 2; i++) begin
                    n_chk++;
                    if (act_vec(i) !== exp_vec(i)) begin
                        n_err++;
                        $display("FAIL walk dut%0d got=%h exp=%h", i, act_vec(i), exp_vec(i));
                    end
                end
            end
            n_chk++;
            if (st_a !== 3'(exp_st[j]) || la != 5 || lb != 2) begin
                n_err++;
                $display("FAIL walk_step%0d st=%0d exp=%0d lat=%0d/%0d exp 5/2",
                         j, st_a, exp_st[j], la, lb);
            end
        end
        n_chk++;
        if (tc_a !== 8'd5 || tc_b !== 8'd5) begin
            n_err++;
            $display("FAIL walk_cnt got=%0d/%0d exp=5", tc_a, tc_b);
        end
    endtask

    task automatic test_illegal();
        int pulses;
        do_reset();
        sw = 3'b100;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ill_a) pulses++;
            n_chk++;
            if (ill_a !== m_ill[0]) begin
                n_err++;
                $display("FAIL illegal_cyc%0d got=%b exp=%b", c, ill_a, m_ill[0]);
            end
        end
        n_chk++;
        if (pulses != 1 || st_a !== 3'd0 || tc_a !== 8'd0) begin
            n_err++;
            $display("FAIL illegal pulses=%0d st=%0d tc=%0d exp 1/0/0", pulses, st_a, tc_a);
        end
        sw = 3'b001;
        cyc(10);
        n_chk++;
        if (st_a !== 3'd1) begin
            n_err++;
            $display("FAIL illegal_then_st1 got=%0d exp=1", st_a);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        do_reset();
        sw = 3'b001;
        cyc(3);
        sw = 3'b000;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ill_a) pulses++;
        end
        n_chk++;
        if (st_a !== 3'd0 || pulses != 0) begin
            n_err++;
            $display("FAIL glitch st=%0d pulses=%0d exp 0/0", st_a, pulses);
        end
        sw = 3'b001;
        cyc(4);
        n_chk++;
        if (st_a !== 3'd0) begin
            n_err++;
            $display("FAIL glitch_early got=%0d exp=0", st_a);
        end
        cyc(1);
        n_chk++;
        if (st_a !== 3'd1) begin
            n_err++;
            $display("FAIL glitch_take got=%0d exp=1", st_a);
        end
    endtask

    task automatic test_blink();
        int pulses;
        logic [2:0] el;
        mode = 1'b1;
        sw = 3'b100;
        cyc(5);
        n_chk++;
        if (st_a !== 3'd3 || led_a !== 3'b100) begin
            n_err++;
            $display("FAIL blink_start st=%0d led=%b exp 3/100", st_a, led_a);
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            el = (((n / 8) % 2) == 0) ? 3'b100 : 3'b000;
            n_chk++;
            if (led_a !== el) begin
                n_err++;
                $display("FAIL blink_n%0d led=%b exp=%b", n, led_a, el);
            end
            n_chk++;
            if (act_vec(1) !== exp_vec(1)) begin
                n_err++;
                $display("FAIL blink_b got=%h exp=%h", act_vec(1), exp_vec(1));
            end
        end
        sw = 3'b011;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ill_a) pulses++;
        end
        n_chk++;
        if (st_a !== 3'd3 || pulses != 0) begin
            n_err++;
            $display("FAIL unmapped st=%0d pulses=%0d exp 3/0", st_a, pulses);
        end
        mode = 1'b0;
        cyc(1);
        n_chk++;
        if (led_a !== 3'b100) begin
            n_err++;
            $display("FAIL steady_led got=%b exp=100", led_a);
        end
    endtask

    task automatic test_saturation();
        for (int t = 0; t < 130; t++) begin
            sw = 3'b111;
            cyc(5);
            sw = 3'b100;
            cyc(5);
            n_chk++;
            if (act_vec(0) !== exp_vec(0)) begin
                n_err++;
                $display("FAIL sat_iter%0d got=%h exp=%h", t, act_vec(0), exp_vec(0));
            end
        end
        n_chk++;
        if (tc_a !== 8'd255 || tc_b !== 8'd255 || st_a !== 3'd3) begin
            n_err++;
            $display("FAIL saturate tc=%0d/%0d st=%0d exp 255/255/3", tc_a, tc_b, st_a);
        end
        sw = 3'b111;
        cyc(5);
        n_chk++;
        if (st_a !== 3'd4 || tc_a !== 8'd255) begin
            n_err++;
            $display("FAIL sat_advance st=%0d tc=%0d exp 4/255", st_a, tc_a);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        for (int s = 0; s < 150; s++) begin
            sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) mode = ~mode;
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    n_chk++;
                    if (act_vec(i) !== exp_vec(i)) begin
                        n_err++;
                        $display("FAIL random dut%0d seg%0d got=%h exp=%h",
                                 i, s, act_vec(i), exp_vec(i));
                    end
                end
            end
        end
    endtask

    initial begin
        foreach (legal_tab[f, t]) legal_tab[f][t] = 1'b0;
        legal_tab[0][1] = 1'b1; legal_tab[0][2] = 1'b1;
        legal_tab[1][2] = 1'b1; legal_tab[1][3] = 1'b1;
        legal_tab[2][3] = 1'b1;
        legal_tab[3][4] = 1'b1; legal_tab[3][0] = 1'b1;
        legal_tab[4][3] = 1'b1;
        test_reset();
        test_walk();
        test_illegal();
        test_glitch();
        test_blink();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
